// File: rtl/hilo_unit_if.sv
// Bus between the HI/LO sequencer and its surroundings: start requests, Div/Mult
// result buses, move-to-HI/LO writes, and the sequencer's enables and status.
interface hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic             mult_start;
  logic [WIDTH-1:0] div_hi_in;
  logic [WIDTH-1:0] div_lo_in;
  logic             div_by_zero;
  logic [WIDTH-1:0] mult_hi_in;
  logic [WIDTH-1:0] mult_lo_in;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] mt_data;
  logic             do_div;
  logic             do_mult;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div0_exc;

  modport master (
    output div_start, mult_start, div_hi_in, div_lo_in, div_by_zero,
           mult_hi_in, mult_lo_in, mthi, mtlo, mt_data,
    input  do_div, do_mult, hi_out, lo_out, busy, done, div0_exc
  );

  modport slave (
    input  div_start, mult_start, div_hi_in, div_lo_in, div_by_zero,
           mult_hi_in, mult_lo_in, mthi, mtlo, mt_data,
    output do_div, do_mult, hi_out, lo_out, busy, done, div0_exc
  );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO sequencer: holds do_div/do_mult for LATENCY cycles while the combinational
// units settle, commits their results, services mthi/mtlo, flags divide-by-zero.
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 32
) (
  input  logic       clk,
  input  logic       reset,
  hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic {OP_DIV, OP_MULT} op_t;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_op_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic             r_abort, w_abort_nxt;
  logic [WIDTH-1:0] r_hi, w_hi_nxt;
  logic [WIDTH-1:0] r_lo, w_lo_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_DIV;
      r_cnt   <= '0;
      r_abort <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_cnt   <= w_cnt_nxt;
      r_abort <= w_abort_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = r_abort;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE, S_DONE: begin
        // Moves and a launch may share a cycle; the later commit overwrites the move.
        w_state_nxt = S_IDLE;
        w_abort_nxt = 1'b0;
        if (bus.mthi) w_hi_nxt = bus.mt_data;
        if (bus.mtlo) w_lo_nxt = bus.mt_data;
        if (bus.div_start) begin
          w_state_nxt = S_RUN;
          w_op_nxt    = OP_DIV;
          w_cnt_nxt   = CNT_LOAD;
        end else if (bus.mult_start) begin
          w_state_nxt = S_RUN;
          w_op_nxt    = OP_MULT;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      S_RUN: begin
        // A zero divisor is only honoured on the first RUN cycle of a divide.
        if (r_cnt == CNT_LOAD && r_op == OP_DIV && bus.div_by_zero) begin
          w_state_nxt = S_DONE;
          w_abort_nxt = 1'b1;
        end else if (r_cnt != 8'd0) begin
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = S_DONE;
          w_hi_nxt    = (r_op == OP_DIV) ? bus.div_hi_in : bus.mult_hi_in;
          w_lo_nxt    = (r_op == OP_DIV) ? bus.div_lo_in : bus.mult_lo_in;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy     = (r_state == S_RUN);
  assign bus.do_div   = (r_state == S_RUN) && (r_op == OP_DIV);
  assign bus.do_mult  = (r_state == S_RUN) && (r_op == OP_MULT);
  assign bus.done     = (r_state == S_DONE);
  assign bus.div0_exc = (r_state == S_DONE) && r_abort;
  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: directed scenarios plus random traffic, every cycle compared
// against a cycle-window model of the RUN/DONE timeline and the HI/LO contents.
module tb_hilo_unit;
  localparam int W   = 32;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_unit_if #(.WIDTH(W)) bus ();

  hilo_unit #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the operation is described by absolute cycle numbers of its RUN window and done pulse.
  int           t  = 0;
  int           rf = -1;
  int           rl = -1;
  int           dn = -1;
  bit           m_mult  = 1'b0;
  bit           m_exc   = 1'b0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  logic         o_dd, o_dm, o_busy, o_done, o_exc;
  logic [W-1:0] o_hi, o_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  task automatic idle_in();
    bus.div_start   = 1'b0;
    bus.mult_start  = 1'b0;
    bus.div_hi_in   = '0;
    bus.div_lo_in   = '0;
    bus.div_by_zero = 1'b0;
    bus.mult_hi_in  = '0;
    bus.mult_lo_in  = '0;
    bus.mthi        = 1'b0;
    bus.mtlo        = 1'b0;
    bus.mt_data     = '0;
  endtask

  // One clock: check this cycle's outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    bit mb;
    @(negedge clk);
    o_dd   = bus.do_div;
    o_dm   = bus.do_mult;
    o_busy = bus.busy;
    o_done = bus.done;
    o_exc  = bus.div0_exc;
    o_hi   = bus.hi_out;
    o_lo   = bus.lo_out;
    mb = (t >= rf) && (t <= rl);
    if (m_valid) begin
      chk("busy",     64'(o_busy), 64'(mb));
      chk("do_div",   64'(o_dd),   64'(mb && !m_mult));
      chk("do_mult",  64'(o_dm),   64'(mb && m_mult));
      chk("done",     64'(o_done), 64'(t == dn));
      chk("div0_exc", 64'(o_exc),  64'((t == dn) && m_exc));
      chk("hi_out",   64'(o_hi),   64'(m_hi));
      chk("lo_out",   64'(o_lo),   64'(m_lo));
    end
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b1;
      rf = -1; rl = -1; dn = -1;
      m_hi = '0; m_lo = '0; m_mult = 1'b0; m_exc = 1'b0;
    end else if (!mb) begin
      if (bus.mthi) m_hi = bus.mt_data;
      if (bus.mtlo) m_lo = bus.mt_data;
      if (bus.div_start || bus.mult_start) begin
        rf = t + 1; rl = t + LAT; dn = t + LAT + 1;
        m_mult = !bus.div_start;
        m_exc  = 1'b0;
      end
    end else begin
      if (t == rf && !m_mult && bus.div_by_zero) begin
        rl = t; dn = t + 1; m_exc = 1'b1;
      end else if (t == rl) begin
        m_hi = m_mult ? bus.mult_hi_in : bus.div_hi_in;
        m_lo = m_mult ? bus.mult_lo_in : bus.div_lo_in;
      end
    end
    t++;
    #1;
  endtask

  initial begin
    int n_dd;
    bit done_seen;
    logic [W-1:0] a, b;

    idle_in();
    reset = 1'b1;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_hi", 64'(o_hi), 64'd0);
    chk("rst_lo", 64'(o_lo), 64'd0);
    chk("rst_flags", 64'({o_dd, o_dm, o_busy, o_done, o_exc}), 64'd0);

    bus.mthi = 1'b1;
    bus.mt_data = 32'hDEADBEEF;
    cycle();
    idle_in();
    cycle();
    chk("mthi_write", 64'(o_hi), 64'h0000_0000_DEAD_BEEF);

    // Divide 100/7 with the Div unit's outputs computed here.
    a = 32'd100;
    b = 32'd7;
    bus.div_start = 1'b1;
    cycle();
    idle_in();
    bus.div_hi_in = a % b;
    bus.div_lo_in = a / b;
    n_dd = 0;
    for (int i = 1; i <= LAT + 1; i++) begin
      cycle();
      if (o_dd) n_dd++;
      if (i <= LAT) chk("div_no_early_done", 64'(o_done), 64'd0);
    end
    chk("div_en_cycles", 64'(n_dd), 64'(LAT));
    chk("div_done", 64'(o_done), 64'd1);
    chk("div_lo", 64'(o_lo), 64'd14);
    chk("div_hi", 64'(o_hi), 64'd2);
    chk("div_exc", 64'(o_exc), 64'd0);

    // Divide by zero with HI/LO preset to 5/6.
    idle_in();
    bus.mthi = 1'b1;
    bus.mt_data = 32'd5;
    cycle();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b1;
    bus.mt_data = 32'd6;
    cycle();
    idle_in();
    bus.div_start = 1'b1;
    cycle();
    idle_in();
    bus.div_by_zero = 1'b1;
    cycle();
    chk("dz_do_div_c1", 64'(o_dd), 64'd1);
    bus.div_by_zero = 1'b0;
    cycle();
    chk("dz_done", 64'(o_done), 64'd1);
    chk("dz_exc", 64'(o_exc), 64'd1);
    chk("dz_do_div_c2", 64'(o_dd), 64'd0);
    chk("dz_hi", 64'(o_hi), 64'd5);
    chk("dz_lo", 64'(o_lo), 64'd6);

    // Simultaneous starts, then ignored start/move during RUN, then back-to-back multiply.
    idle_in();
    bus.div_start  = 1'b1;
    bus.mult_start = 1'b1;
    bus.div_hi_in  = 32'hAAAA;
    bus.div_lo_in  = 32'h5555;
    bus.mult_hi_in = 32'h1111;
    bus.mult_lo_in = 32'h2222;
    cycle();
    bus.div_start  = 1'b0;
    bus.mult_start = 1'b1;
    bus.mtlo       = 1'b1;
    bus.mt_data    = 32'h1234;
    cycle();
    chk("both_do_div", 64'(o_dd), 64'd1);
    chk("both_do_mult", 64'(o_dm), 64'd0);
    bus.mult_start = 1'b0;
    bus.mtlo       = 1'b0;
    repeat (LAT - 1) cycle();
    bus.mult_start = 1'b1;
    bus.mult_hi_in = 32'd1;
    bus.mult_lo_in = 32'd0;
    cycle();
    chk("both_done", 64'(o_done), 64'd1);
    chk("both_hi", 64'(o_hi), 64'hAAAA);
    chk("both_lo", 64'(o_lo), 64'h5555);
    chk("lo_not_moved", 64'(o_lo == 32'h1234), 64'd0);
    bus.mult_start = 1'b0;
    repeat (LAT) cycle();
    cycle();
    chk("b2b_done", 64'(o_done), 64'd1);
    chk("b2b_hi", 64'(o_hi), 64'd1);
    chk("b2b_lo", 64'(o_lo), 64'd0);

    // Reset in the second RUN cycle.
    idle_in();
    bus.div_start = 1'b1;
    cycle();
    idle_in();
    cycle();
    reset = 1'b1;
    cycle();
    chk("rr_busy_before", 64'(o_busy), 64'd1);
    reset = 1'b0;
    cycle();
    chk("rr_do_div", 64'(o_dd), 64'd0);
    chk("rr_busy", 64'(o_busy), 64'd0);
    chk("rr_hi", 64'(o_hi), 64'd0);
    chk("rr_lo", 64'(o_lo), 64'd0);
    done_seen = (o_done === 1'b1);
    repeat (LAT + 2) begin
      cycle();
      if (o_done === 1'b1) done_seen = 1'b1;
    end
    chk("rr_no_done", 64'(done_seen), 64'd0);

    // Random traffic against the model.
    repeat (500) begin
      bus.div_start   = ($urandom_range(0, 5) == 0);
      bus.mult_start  = ($urandom_range(0, 5) == 0);
      bus.div_by_zero = ($urandom_range(0, 3) == 0);
      bus.mthi        = ($urandom_range(0, 4) == 0);
      bus.mtlo        = ($urandom_range(0, 4) == 0);
      bus.mt_data     = $urandom;
      bus.div_hi_in   = $urandom;
      bus.div_lo_in   = $urandom;
      bus.mult_hi_in  = $urandom;
      bus.mult_lo_in  = $urandom;
      reset           = ($urandom_range(0, 79) == 0);
      cycle();
    end
    idle_in();
    reset = 1'b0;
    repeat (LAT + 2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequencer and result store for the HI/LO register pair in the multicycle datapath. Launches a divide or multiply by asserting `do_div`/`do_mult` toward the combinational Div and Mult units. Holds that enable for a fixed settle latency, then commits their HI/LO outputs. Also services `mthi`/`mtlo` writes and raises a one-cycle divide-by-zero exception toward the control unit.

## Interface
- `WIDTH`, 32, data width of HI, LO and all operand/result buses
- `LATENCY`, 32, cycles `do_div`/`do_mult` stay high before commit; legal range 2..255
- `clk` input 1, rising-edge clock
- `reset` input 1, synchronous, active-high; one clock, every flop cleared on the edge where `reset`=1
- `div_start` input 1, single-cycle request to run a divide
- `mult_start` input 1, single-cycle request to run a multiply
- `div_hi_in` input WIDTH, remainder from Div
- `div_lo_in` input WIDTH, quotient from Div
- `div_by_zero` input 1, zero-divisor flag from Div
- `mult_hi_in` input WIDTH, upper product from Mult
- `mult_lo_in` input WIDTH, lower product from Mult
- `mthi` input 1, write `mt_data` into HI
- `mtlo` input 1, write `mt_data` into LO
- `mt_data` input WIDTH, data for `mthi`/`mtlo`
- `do_div` output 1, enable to Div; high throughout a divide RUN
- `do_mult` output 1, enable to Mult; high throughout a multiply RUN
- `hi_out` output WIDTH, current HI register
- `lo_out` output WIDTH, current LO register
- `busy` output 1, high in RUN
- `done` output 1, one-cycle completion pulse
- `div0_exc` output 1, one-cycle divide-by-zero pulse, coincident with `done`

## Operation
- States: IDLE, RUN, DONE. An `op` flop records DIV or MULT. A countdown `cnt` is 8 bits.
- Reset values: state IDLE, `cnt`=0, `op`=DIV, `hi_out`=0, `lo_out`=0. `do_div`, `do_mult`, `busy`, `done`, `div0_exc` are all 0.
- IDLE or DONE, `div_start`=1: enter RUN with `op`=DIV and `cnt`=LATENCY-1.
- IDLE or DONE, `mult_start`=1 (and `div_start`=0): enter RUN with `op`=MULT and `cnt`=LATENCY-1.
- Both starts high in the same cycle: divide wins and the multiply is dropped.
- IDLE or DONE, no start: next state is IDLE.
- DONE always lasts exactly one cycle.
- RUN: `busy`=1. `do_div` = (`op`==DIV) and `do_mult` = (`op`==MULT), both decoded directly from state.
- RUN, first cycle (`cnt`==LATENCY-1), `op`==DIV, `div_by_zero`=1: abort to DONE.
  - HI and LO are left unchanged.
  - DONE asserts `done`=1 and `div0_exc`=1.
- RUN, `cnt`!=0: decrement `cnt`.
- RUN, `cnt`==0: load HI/LO from the `div_*_in` or `mult_*_in` pair selected by `op`, then enter DONE.
- DONE: `done`=1. `div0_exc`=1 only when the operation aborted; a dedicated flag records this.
- Starts asserted during RUN are ignored and not queued.
- `mthi`/`mtlo` apply only in IDLE or DONE. Each writes `mt_data` on the clock edge; both high writes both registers. In RUN they are ignored.
- A start and an `mthi`/`mtlo` in the same IDLE cycle: the move is performed and the operation also launches. The commit later overwrites the moved value.
- `reset` during RUN: return to IDLE and clear HI/LO. No `done` pulse.

## Timing
- Start sampled at edge k: RUN covers cycles k+1 … k+LATENCY.
- Commit happens at edge k+LATENCY. `done` is high during cycle k+LATENCY+1, and the new `hi_out`/`lo_out` are visible in that same cycle.
- Div-by-zero abort: `done`/`div0_exc` are high during cycle k+2 and `do_div` is high for exactly one cycle.
- Back-to-back operations: a start during the `done` cycle launches with no IDLE gap.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.

## Test plan
- Reset hold for 2 cycles, then release → `hi_out`=`lo_out`=0 and all flags 0. Issue `mthi` with `mt_data`=0xDEADBEEF → `hi_out`=0xDEADBEEF on the next cycle.
- LATENCY=4. Pulse `div_start`; model Div computing 100/7 from `do_div` → `do_div` high for exactly 4 cycles, `done` in the 5th cycle, `lo_out`=14, `hi_out`=2, `div0_exc`=0.
- Divisor 0 (`div_by_zero`=1 while `do_div`=1) with HI/LO preset to 5/6 → `done` and `div0_exc` high in cycle 2 after the start; HI/LO remain 5/6.
- `div_start` and `mult_start` in the same cycle; then `mult_start` and `mtlo` (0x1234) during RUN → a divide result is committed, the mid-run start and move are ignored, and `lo_out` is not 0x1234.
- Mult 0x10000×0x10000 (`mult_hi_in`=1, `mult_lo_in`=0) launched in the `done` cycle of a previous divide → second commit exactly LATENCY+1 cycles later gives HI=1, LO=0.
- Assert `reset` at the 2nd RUN cycle → IDLE on the next cycle, `do_div`=0, HI/LO=0, no `done` pulse ever seen.
